// File: rtl/rle_enc_param.sv
`default_nettype none
// ============================================================================
// Module   : rle_enc_param
// Brief    : Parametrised run-length encoder with per-beat end-of-packet.
//            Emits {symbol, count, last} runs over a valid/ready output.
//            Optional on-demand run flush enabled by macro RLE_ENC_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rle_enc_param #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int COUNT_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef RLE_ENC_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic [SYMBOL_WIDTH-1:0] in_data,
    input  logic                    in_last,
    input  logic                    in_vld,
    output logic                    in_rdy,
    output logic [SYMBOL_WIDTH-1:0] out_symbol,
    output logic [COUNT_WIDTH-1:0]  out_count,
    output logic                    out_last,
    output logic                    out_vld,
    input  logic                    out_rdy
);

    localparam logic [COUNT_WIDTH-1:0] c_MAXC = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] c_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    // TAIL holds the single-symbol run left over when a split lands on in_last
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [SYMBOL_WIDTH-1:0]   r_run_sym;
    logic [SYMBOL_WIDTH-1:0]   w_sym_nxt;
    logic [COUNT_WIDTH-1:0]    r_run_cnt;
    logic [COUNT_WIDTH-1:0]    w_cnt_nxt;

    logic                      r_out_vld;
    logic [SYMBOL_WIDTH-1:0]   r_out_sym;
    logic [COUNT_WIDTH-1:0]    r_out_cnt;
    logic                      r_out_last;

    logic                      w_out_free;
    logic                      w_accept;
    logic                      w_emit;
    logic [SYMBOL_WIDTH-1:0]   w_emit_sym;
    logic [COUNT_WIDTH-1:0]    w_emit_cnt;
    logic                      w_emit_last;

    assign w_out_free = ~r_out_vld | out_rdy;
    assign in_rdy     = ~reset & (r_state != ST_TAIL) & w_out_free;
    assign w_accept   = in_vld & in_rdy;

    assign out_vld    = r_out_vld;
    assign out_symbol = r_out_sym;
    assign out_count  = r_out_cnt;
    assign out_last   = r_out_last;

    // Run state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_run_sym <= '0;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_sym <= w_sym_nxt;
            r_run_cnt <= w_cnt_nxt;
        end
    end

    // Next-state and emission decision; every emission path implies out_free
    always_comb begin
        w_state_nxt = r_state;
        w_sym_nxt   = r_run_sym;
        w_cnt_nxt   = r_run_cnt;
        w_emit      = 1'b0;
        w_emit_sym  = r_run_sym;
        w_emit_cnt  = r_run_cnt;
        w_emit_last = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_emit      = 1'b1;
                        w_emit_sym  = in_data;
                        w_emit_cnt  = c_ONE;
                        w_emit_last = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_sym_nxt   = in_data;
                        w_cnt_nxt   = c_ONE;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if ((in_data == r_run_sym) && (r_run_cnt != c_MAXC)) begin
                        if (in_last) begin
                            w_emit      = 1'b1;
                            w_emit_cnt  = r_run_cnt + c_ONE;
                            w_emit_last = 1'b1;
                            w_state_nxt = ST_EMPTY;
                        end else begin
                            w_cnt_nxt   = r_run_cnt + c_ONE;
                        end
                    end else begin
                        // Close the current run and open a new one with this beat
                        w_emit      = 1'b1;
                        w_sym_nxt   = in_data;
                        w_cnt_nxt   = c_ONE;
                        w_state_nxt = in_last ? ST_TAIL : ST_RUN;
                    end
                end
`ifdef RLE_ENC_FLUSH_EN
                else if (flush && !in_vld && w_out_free) begin
                    w_emit      = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
`endif
            end
            ST_TAIL: begin
                if (w_out_free) begin
                    w_emit      = 1'b1;
                    w_emit_last = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Output register: load on emission, drop valid after a handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld  <= 1'b0;
            r_out_sym  <= '0;
            r_out_cnt  <= '0;
            r_out_last <= 1'b0;
        end else if (w_emit) begin
            r_out_vld  <= 1'b1;
            r_out_sym  <= w_emit_sym;
            r_out_cnt  <= w_emit_cnt;
            r_out_last <= w_emit_last;
        end else if (out_rdy) begin
            r_out_vld  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
